// File: rtl/gobang_move_ctrl.sv
// Move/undo sequencer for the gobang board datapath: validates and writes stones,
// detects five-in-a-row, tracks the side to move and keeps a LIFO history for retract.
module gobang_move_ctrl #(
    parameter int unsigned BOARD_SIZE = 15,
    parameter int unsigned HIST_DEPTH = 225,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  move_req,
    input  logic [3:0]            move_i,
    input  logic [3:0]            move_j,
    input  logic                  retract_req,
    output logic                  move_ack,
    output logic                  move_rej,
    output logic                  retract_ack,
    output logic                  retract_rej,
    output logic                  busy,
    output logic                  cur_color,
    output logic                  game_over,
    output logic                  winner,
    output logic                  board_full,
    output logic [CNT_W-1:0]      move_count,
    output logic                  dp_clr,
    output logic                  dp_write,
    output logic                  dp_retract,
    output logic [3:0]            dp_write_i,
    output logic [3:0]            dp_write_j,
    output logic                  dp_write_color,
    output logic [3:0]            dp_logic_i,
    input  logic [BOARD_SIZE-1:0] dp_logic_row,
    output logic [3:0]            dp_consider_i,
    output logic [3:0]            dp_consider_j,
    input  logic [8:0]            dp_black_i,
    input  logic [8:0]            dp_black_j,
    input  logic [8:0]            dp_black_ij,
    input  logic [8:0]            dp_black_ji,
    input  logic [8:0]            dp_white_i,
    input  logic [8:0]            dp_white_j,
    input  logic [8:0]            dp_white_ij,
    input  logic [8:0]            dp_white_ji
);

    localparam logic [3:0]       EdgeLen = 4'(BOARD_SIZE);
    localparam logic [CNT_W-1:0] FullCnt = CNT_W'(HIST_DEPTH);

    typedef enum logic [2:0] {StIdle, StChk, StWr, StWin, StRet} state_e;

    state_e           state_q;
    logic             move_ack_q, move_rej_q, retract_ack_q, retract_rej_q;
    logic             cur_color_q, game_over_q, winner_q;
    logic [CNT_W-1:0] move_count_q;
    logic             dp_write_q, dp_retract_q, dp_write_color_q;
    logic [3:0]       dp_write_i_q, dp_write_j_q, dp_logic_i_q;
    logic [3:0]       dp_consider_i_q, dp_consider_j_q;

    // History entry: {colour, row, column}; move_count doubles as the stack pointer.
    logic [8:0]       stack_q [HIST_DEPTH];
    logic [8:0]       top_entry;
    logic [15:0]      row_ext;
    logic             illegal;
    logic             five_found;

    function automatic logic has_five(input logic [8:0] w);
        logic f;
        f = 1'b0;
        for (int k = 0; k < 5; k++) begin
            f = f | (w[k +: 5] == 5'b11111);
        end
        return f;
    endfunction

    assign top_entry  = stack_q[move_count_q - CNT_W'(1)];
    assign row_ext    = 16'(dp_logic_row);
    assign board_full = (move_count_q == FullCnt);
    assign illegal    = (dp_write_i_q >= EdgeLen) || (dp_write_j_q >= EdgeLen) ||
                        row_ext[dp_write_j_q] || board_full;
    assign five_found = cur_color_q
        ? (has_five(dp_white_i) | has_five(dp_white_j) | has_five(dp_white_ij) |
           has_five(dp_white_ji))
        : (has_five(dp_black_i) | has_five(dp_black_j) | has_five(dp_black_ij) |
           has_five(dp_black_ji));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            move_ack_q       <= 1'b0;
            move_rej_q       <= 1'b0;
            retract_ack_q    <= 1'b0;
            retract_rej_q    <= 1'b0;
            cur_color_q      <= 1'b0;
            game_over_q      <= 1'b0;
            winner_q         <= 1'b0;
            move_count_q     <= '0;
            dp_write_q       <= 1'b0;
            dp_retract_q     <= 1'b0;
            dp_write_color_q <= 1'b0;
            dp_write_i_q     <= '0;
            dp_write_j_q     <= '0;
            dp_logic_i_q     <= '0;
            dp_consider_i_q  <= '0;
            dp_consider_j_q  <= '0;
        end else if (clr) begin
            state_q       <= StIdle;
            move_ack_q    <= 1'b0;
            move_rej_q    <= 1'b0;
            retract_ack_q <= 1'b0;
            retract_rej_q <= 1'b0;
            dp_write_q    <= 1'b0;
            dp_retract_q  <= 1'b0;
            cur_color_q   <= 1'b0;
            game_over_q   <= 1'b0;
            winner_q      <= 1'b0;
            move_count_q  <= '0;
        end else begin
            move_ack_q    <= 1'b0;
            move_rej_q    <= 1'b0;
            retract_ack_q <= 1'b0;
            retract_rej_q <= 1'b0;
            dp_write_q    <= 1'b0;
            dp_retract_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Retract has priority; a simultaneous move request is dropped.
                    if (retract_req) begin
                        if (move_count_q == '0) begin
                            retract_rej_q <= 1'b1;
                        end else begin
                            {dp_write_color_q, dp_write_i_q, dp_write_j_q} <= top_entry;
                            dp_retract_q <= 1'b1;
                            state_q      <= StRet;
                        end
                    end else if (move_req) begin
                        if (game_over_q) begin
                            move_rej_q <= 1'b1;
                        end else begin
                            dp_logic_i_q <= move_i;
                            dp_write_i_q <= move_i;
                            dp_write_j_q <= move_j;
                            state_q      <= StChk;
                        end
                    end
                end
                StChk: begin
                    if (illegal) begin
                        move_rej_q <= 1'b1;
                        state_q    <= StIdle;
                    end else begin
                        dp_write_q       <= 1'b1;
                        dp_write_color_q <= cur_color_q;
                        state_q          <= StWr;
                    end
                end
                StWr: begin
                    dp_consider_i_q <= dp_write_i_q;
                    dp_consider_j_q <= dp_write_j_q;
                    state_q         <= StWin;
                end
                StWin: begin
                    move_ack_q   <= 1'b1;
                    move_count_q <= move_count_q + CNT_W'(1);
                    cur_color_q  <= ~cur_color_q;
                    if (five_found) begin
                        game_over_q <= 1'b1;
                        winner_q    <= cur_color_q;
                    end
                    state_q <= StIdle;
                end
                StRet: begin
                    cur_color_q   <= dp_write_color_q;
                    move_count_q  <= move_count_q - CNT_W'(1);
                    game_over_q   <= 1'b0;
                    winner_q      <= 1'b0;
                    retract_ack_q <= 1'b1;
                    state_q       <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clr && state_q == StWr) begin
            stack_q[move_count_q] <= {dp_write_color_q, dp_write_i_q, dp_write_j_q};
        end
    end

    assign move_ack       = move_ack_q;
    assign move_rej       = move_rej_q;
    assign retract_ack    = retract_ack_q;
    assign retract_rej    = retract_rej_q;
    assign busy           = (state_q != StIdle);
    assign cur_color      = cur_color_q;
    assign game_over      = game_over_q;
    assign winner         = winner_q;
    assign move_count     = move_count_q;
    assign dp_clr         = clr;
    assign dp_write       = dp_write_q;
    assign dp_retract     = dp_retract_q;
    assign dp_write_i     = dp_write_i_q;
    assign dp_write_j     = dp_write_j_q;
    assign dp_write_color = dp_write_color_q;
    assign dp_logic_i     = dp_logic_i_q;
    assign dp_consider_i  = dp_consider_i_q;
    assign dp_consider_j  = dp_consider_j_q;

endmodule

// File: tb/tb_gobang_move_ctrl.sv
// Scoreboard bench for gobang_move_ctrl: a board datapath model feeds the DUT, a game-rule
// reference model predicts every strobe and pulse, and a monitor checks them as they appear.
module tb_gobang_move_ctrl;

    localparam int N = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       move_req = 1'b0;
    logic       retract_req = 1'b0;
    logic [3:0] move_i = '0;
    logic [3:0] move_j = '0;
    logic       move_ack, move_rej, retract_ack, retract_rej, busy;
    logic       cur_color, game_over, winner, board_full;
    logic [7:0] move_count;
    logic       dp_clr, dp_write, dp_retract, dp_write_color;
    logic [3:0] dp_write_i, dp_write_j, dp_logic_i, dp_consider_i, dp_consider_j;
    logic [14:0] dp_logic_row;
    logic [8:0] wb [4];
    logic [8:0] ww [4];

    gobang_move_ctrl dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .move_req(move_req),
        .move_i(move_i), .move_j(move_j), .retract_req(retract_req),
        .move_ack(move_ack), .move_rej(move_rej), .retract_ack(retract_ack),
        .retract_rej(retract_rej), .busy(busy), .cur_color(cur_color),
        .game_over(game_over), .winner(winner), .board_full(board_full),
        .move_count(move_count), .dp_clr(dp_clr), .dp_write(dp_write),
        .dp_retract(dp_retract), .dp_write_i(dp_write_i), .dp_write_j(dp_write_j),
        .dp_write_color(dp_write_color), .dp_logic_i(dp_logic_i),
        .dp_logic_row(dp_logic_row), .dp_consider_i(dp_consider_i),
        .dp_consider_j(dp_consider_j),
        .dp_black_i(wb[0]), .dp_black_j(wb[1]), .dp_black_ij(wb[2]), .dp_black_ji(wb[3]),
        .dp_white_i(ww[0]), .dp_white_j(ww[1]), .dp_white_ij(ww[2]), .dp_white_ji(ww[3])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Board datapath model: {occupied, colour} per cell.
    localparam int DR [4] = '{1, 0, 1, 1};
    localparam int DC [4] = '{0, 1, 1, -1};
    logic [1:0] dpb [N][N];

    always @(posedge clk) begin
        if (!rst_n || dp_clr) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) dpb[r][c] <= 2'b00;
        end else if (dp_write && dp_write_i < 4'd15 && dp_write_j < 4'd15) begin
            dpb[dp_write_i][dp_write_j] <= {1'b1, dp_write_color};
        end else if (dp_retract && dp_write_i < 4'd15 && dp_write_j < 4'd15) begin
            dpb[dp_write_i][dp_write_j] <= 2'b00;
        end
    end

    always_comb begin
        int r, c;
        r = 0;
        c = 0;
        dp_logic_row = '0;
        wb = '{default: '0};
        ww = '{default: '0};
        if (dp_logic_i < 4'd15)
            for (int j = 0; j < N; j++) dp_logic_row[j] = dpb[int'(dp_logic_i)][j][1];
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 9; k++) begin
                r = int'(dp_consider_i) + (k - 4) * DR[d];
                c = int'(dp_consider_j) + (k - 4) * DC[d];
                if (r >= 0 && r < N && c >= 0 && c < N) begin
                    wb[d][k] = dpb[r][c][1] & ~dpb[r][c][0];
                    ww[d][k] = dpb[r][c][1] &  dpb[r][c][0];
                end
            end
        end
    end

    // Reference model of the game rules.
    typedef enum int {EvWrite, EvRet, EvAck, EvRej, EvRAck, EvRRej} ev_e;
    typedef struct {
        ev_e kind; int cyc; int i; int j; int col; int cnt; int cur; int go; int win;
    } exp_t;
    typedef struct { int i; int j; int c; } hist_t;

    exp_t  sb [$];
    hist_t hist [$];
    int    mb [N][N];
    int    m_cur, m_go, m_win, m_cnt;
    int    errors = 0;
    int    checks = 0;

    function automatic void model_reset();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) mb[r][c] = -1;
        hist.delete();
        m_cur = 0; m_go = 0; m_win = 0; m_cnt = 0;
    endfunction

    function automatic void push_ev(ev_e kind, int at, int i, int j, int col);
        exp_t e;
        e.kind = kind; e.cyc = at; e.i = i; e.j = j; e.col = col;
        e.cnt = m_cnt; e.cur = m_cur; e.go = m_go; e.win = m_win;
        sb.push_back(e);
    endfunction

    function automatic int run_len(int i, int j, int di, int dj, int c);
        int n, r, s;
        n = 0; r = i + di; s = j + dj;
        while (r >= 0 && r < N && s >= 0 && s < N && mb[r][s] == c) begin
            n++; r += di; s += dj;
        end
        return n;
    endfunction

    function automatic void model_move(int i, int j, int base);
        hist_t h;
        int    five;
        if (m_go != 0) push_ev(EvRej, base, 0, 0, 0);
        else if (i >= N || j >= N || m_cnt == N * N) push_ev(EvRej, base + 1, 0, 0, 0);
        else if (mb[i][j] >= 0) push_ev(EvRej, base + 1, 0, 0, 0);
        else begin
            push_ev(EvWrite, base + 1, i, j, m_cur);
            mb[i][j] = m_cur;
            h.i = i; h.j = j; h.c = m_cur;
            hist.push_back(h);
            m_cnt++;
            five = 0;
            for (int d = 0; d < 4; d++)
                if (1 + run_len(i, j, DR[d], DC[d], m_cur) +
                    run_len(i, j, -DR[d], -DC[d], m_cur) >= 5) five = 1;
            if (five != 0) begin m_go = 1; m_win = m_cur; end
            m_cur = 1 - m_cur;
            push_ev(EvAck, base + 3, 0, 0, 0);
        end
    endfunction

    function automatic void model_retract(int base);
        hist_t h;
        if (m_cnt == 0) push_ev(EvRRej, base, 0, 0, 0);
        else begin
            h = hist.pop_back();
            push_ev(EvRet, base, h.i, h.j, h.c);
            mb[h.i][h.j] = -1;
            m_cur = h.c; m_cnt--; m_go = 0; m_win = 0;
            push_ev(EvRAck, base + 1, 0, 0, 0);
        end
    endfunction

    // Monitor: every strobe or pulse must match the oldest expected event.
    task automatic take(ev_e kind);
        exp_t e;
        bit   ok;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s cycle=%0d (nothing expected)", kind.name(), cyc);
            return;
        end
        e = sb.pop_front();
        ok = (e.kind == kind) && (e.cyc == cyc);
        if (kind == EvWrite || kind == EvRet)
            ok = ok && dp_write_i == 4'(e.i) && dp_write_j == 4'(e.j) &&
                 dp_write_color == e.col[0];
        else
            ok = ok && move_count == 8'(e.cnt) && cur_color == e.cur[0] &&
                 game_over == e.go[0] && winner == e.win[0];
        if (!ok) begin
            errors++;
            $display("FAIL event_%s got: kind=%s cyc=%0d ij=%0d,%0d col=%0d cnt=%0d cur=%0d go=%0d win=%0d need: kind=%s cyc=%0d ij=%0d,%0d col=%0d cnt=%0d cur=%0d go=%0d win=%0d",
                     kind.name(), kind.name(), cyc, dp_write_i, dp_write_j, dp_write_color,
                     move_count, cur_color, game_over, winner, e.kind.name(), e.cyc, e.i, e.j,
                     e.col, e.cnt, e.cur, e.go, e.win);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (dp_write)    take(EvWrite);
            if (dp_retract)  take(EvRet);
            if (move_ack)    take(EvAck);
            if (move_rej)    take(EvRej);
            if (retract_ack) take(EvRAck);
            if (retract_rej) take(EvRRej);
            if (dp_write || dp_retract) begin
                checks++;
                if (dp_write && dp_retract) begin
                    errors++;
                    $display("FAIL strobe_excl got both dp_write and dp_retract, need one");
                end
            end
        end
    end

    task automatic chk(string name, int got, int need);
        checks++;
        if (got != need) begin
            errors++;
            $display("FAIL %s got=%0d need=%0d", name, got, need);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 20);
        if (busy) begin
            checks++; errors++;
            $display("FAIL idle_timeout got busy=1 need busy=0 within 20 cycles");
        end
    endtask

    // Called at a negedge with the DUT idle.
    task automatic issue(bit mv, bit rt, int i, int j);
        move_req = mv; retract_req = rt;
        move_i = 4'(i); move_j = 4'(j);
        if (rt) model_retract(cyc + 1);
        else if (mv) model_move(i, j, cyc + 1);
        @(posedge clk); #1;
        move_req = 1'b0; retract_req = 1'b0;
        wait_idle();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    // Starts a move that the caller aborts; only its dp_write strobe is expected.
    task automatic start_move(int i, int j);
        move_req = 1'b1; move_i = 4'(i); move_j = 4'(j);
        push_ev(EvWrite, cyc + 2, i, j, m_cur);
        @(posedge clk); #1;
        move_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int r, i, j;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        chk("rst_busy", busy, 0);
        chk("rst_cur_color", cur_color, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_winner", winner, 0);
        chk("rst_move_count", move_count, 0);
        chk("rst_board_full", board_full, 0);
        chk("rst_strobes", {dp_write, dp_retract, move_ack, move_rej}, 0);
        chk("rst_addr", {dp_write_i, dp_write_j, dp_logic_i, dp_consider_i, dp_consider_j}, 0);

        issue(1, 0, 7, 7);
        chk("t1_cur_color", cur_color, 1);
        chk("t1_move_count", move_count, 1);

        issue(1, 0, 7, 7);
        issue(1, 0, 15, 3);
        chk("t2_move_count", move_count, 1);

        for (int k = 0; k < 4; k++) begin
            issue(1, 0, 0, 2 * k);
            issue(1, 0, 7, 3 + k);
        end
        chk("t3_game_over", game_over, 1);
        chk("t3_winner", winner, 0);
        chk("t3_move_count", move_count, 9);
        issue(1, 0, 2, 2);

        issue(0, 1, 0, 0);
        chk("t4_game_over", game_over, 0);
        chk("t4_cur_color", cur_color, 0);
        chk("t4_move_count", move_count, 8);

        do_clr();
        chk("t5_clr_count", move_count, 0);
        issue(0, 1, 0, 0);
        issue(1, 0, 3, 3);
        issue(1, 1, 4, 4);
        chk("t5_both_count", move_count, 0);

        start_move(5, 5);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        model_reset();
        @(negedge clk);
        chk("t6_clr_busy", busy, 0);
        chk("t6_clr_count", move_count, 0);
        repeat (3) @(negedge clk);

        start_move(6, 6);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_addr", {dp_write_i, dp_write_j, dp_consider_i}, 0);
        chk("t6_rst_flags", {cur_color, move_ack, game_over}, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 99);
            i = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(4, 10);
            j = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(4, 10);
            if (r < 2) do_clr();
            else if (r < 20) issue(0, 1, i, j);
            else if (r < 25) issue(1, 1, i, j);
            else issue(1, 0, i, j);
        end
        chk("rand_move_count", move_count, m_cnt);
        chk("rand_game_over", game_over, m_go);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got running need finished");
        $fatal(1, "timeout");
    end

endmodule
